// File: rtl/alu_op_sequencer_if.sv
// Handshake and operand/result bundle between the control unit and the ALU sequencer.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       aluop;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, aluop, data1, data2,
        input  result, zero, busy, done
    );

    modport slave (
        input  start, aluop, data1, data2,
        output result, zero, busy, done
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU sequencer: single-step logic ops, iterative shift-add multiply and
// bit-serial shifts/rotate, with a registered result and a one-cycle DONE pulse.
module alu_op_sequencer #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_FWD  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MULT = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SRL  = 3'b110;
    localparam logic [2:0] OP_ROR  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t           state, nstate;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] opa_r, opb_r, acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pass_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;

    logic             accept;
    logic             last;
    logic [CNT_W-1:0] load_cnt;
    logic             load_pass;
    logic [WIDTH-1:0] nxt_acc, nxt_opa, nxt_opb, step_val;
    logic             is_shift;
    int               amt_i;
    int               n_i;

    assign accept   = bus.start && (state != S_EXEC);
    assign last     = (cnt_r == CNT_W'(1));
    assign is_shift = op_r[2] && (op_r != OP_MULT);

    // Iteration count for the op being accepted; a zero count becomes one pass-through step.
    always_comb begin
        amt_i = int'(bus.data2[SHAMT_W-1:0]);
        n_i   = 1;
        case (bus.aluop)
            OP_MULT:        n_i = WIDTH;
            OP_SLL, OP_SRL: n_i = (amt_i >= WIDTH) ? WIDTH : amt_i;
            OP_ROR:         n_i = amt_i % WIDTH;
            default:        n_i = 1;
        endcase
        load_pass = (n_i == 0);
        load_cnt  = load_pass ? CNT_W'(1) : CNT_W'(n_i);
    end

    always_comb begin
        nxt_acc = acc_r;
        nxt_opa = opa_r;
        nxt_opb = opb_r;
        case (op_r)
            OP_FWD: nxt_acc = opb_r;
            OP_ADD: nxt_acc = opa_r + opb_r;
            OP_AND: nxt_acc = opa_r & opb_r;
            OP_OR:  nxt_acc = opa_r | opb_r;
            OP_MULT: begin
                if (opb_r[0]) nxt_acc = acc_r + opa_r;
                nxt_opa = opa_r << 1;
                nxt_opb = opb_r >> 1;
            end
            OP_SLL: if (!pass_r) nxt_opa = opa_r << 1;
            OP_SRL: if (!pass_r) nxt_opa = opa_r >> 1;
            OP_ROR: if (!pass_r) nxt_opa = {opa_r[0], opa_r[WIDTH-1:1]};
            default: nxt_acc = acc_r;
        endcase
        step_val = is_shift ? nxt_opa : nxt_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  nstate = accept ? S_EXEC : S_IDLE;
            S_EXEC:  nstate = last ? S_DONE : S_EXEC;
            S_DONE:  nstate = bus.start ? S_EXEC : S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == S_EXEC);
        bus.done = (state == S_DONE);
    end

    // Operand/working registers; RESULT only moves on the final EXEC step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= '0;
            opa_r    <= '0;
            opb_r    <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            pass_r   <= 1'b0;
            result_r <= '0;
            zero_r   <= 1'b1;
        end else if (accept) begin
            op_r   <= bus.aluop;
            opa_r  <= bus.data1;
            opb_r  <= bus.data2;
            acc_r  <= '0;
            cnt_r  <= load_cnt;
            pass_r <= load_pass;
        end else if (state == S_EXEC) begin
            acc_r <= nxt_acc;
            opa_r <= nxt_opa;
            opb_r <= nxt_opb;
            cnt_r <= cnt_r - CNT_W'(1);
            if (last) begin
                result_r <= step_val;
                zero_r   <= (step_val == '0);
            end
        end
    end

    assign bus.result = result_r;
    assign bus.zero   = zero_r;
endmodule
